// File: rtl/hmi_led_sched.sv
// Shared HMI status LED: arbitrates pending events and shows the winner as an idx+1 blink code.
// Build option HMI_LED_SCHED_RR_EN selects round-robin arbitration (default: fixed priority).
module hmi_led_sched #(
    parameter int unsigned TICK_DIV = 50_000,
    parameter int unsigned ON_T     = 200,
    parameter int unsigned OFF_T    = 200,
    parameter int unsigned GAP_T    = 800
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] ev,
    output logic       led_n,
    output logic       busy,
    output logic [2:0] gnt,
    output logic [2:0] pend
);

    localparam int unsigned TW     = $clog2(TICK_DIV);
    localparam int unsigned PH_MAX = (ON_T > OFF_T) ? ((ON_T > GAP_T) ? ON_T : GAP_T)
                                                    : ((OFF_T > GAP_T) ? OFF_T : GAP_T);
    localparam int unsigned PW     = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [1:0]      blk_q, blk_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [2:0]      pend_q, pend_d;
    logic            led_n_q, led_n_d;
    logic            busy_q, busy_d;
    logic [1:0]      last_q, last_d;

    logic [1:0]      win;
    logic            tick;
    logic            ph_done;
    logic [PW-1:0]   ph_last;

`ifdef HMI_LED_SCHED_RR_EN
    logic [1:0] cand;
    logic       found;

    // Search starts one past the last granted source, wrapping at 3.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = 2'((32'(last_q) + k + 1) % 3);
            if (!found && pend_q[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        if (pend_q[0])      win = 2'd0;
        else if (pend_q[1]) win = 2'd1;
        else                win = 2'd2;
    end
`endif

    always_comb begin
        unique case (state_q)
            S_ON:    ph_last = PW'(ON_T - 1);
            S_OFF:   ph_last = PW'(OFF_T - 1);
            default: ph_last = PW'(GAP_T - 1);
        endcase
    end

    assign tick    = (state_q != S_IDLE) && (tick_q == TW'(TICK_DIV - 1));
    assign ph_done = tick && (phase_q == ph_last);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        phase_d = phase_q;
        blk_d   = blk_q;
        gnt_d   = gnt_q;
        pend_d  = pend_q;
        led_n_d = led_n_q;
        busy_d  = busy_q;
        last_d  = last_q;

        if (state_q != S_IDLE) begin
            tick_d = tick ? '0 : tick_q + 1'b1;
            if (tick) phase_d = phase_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    state_d      = S_ON;
                    gnt_d        = 3'b001 << win;
                    blk_d        = win + 2'd1;
                    pend_d[win]  = 1'b0;
                    led_n_d      = 1'b0;
                    busy_d       = 1'b1;
                    tick_d       = '0;
                    phase_d      = '0;
                    last_d       = win;
                end
            end
            S_ON: begin
                if (ph_done) begin
                    state_d = S_OFF;
                    phase_d = '0;
                    led_n_d = 1'b1;
                    blk_d   = blk_q - 2'd1;
                end
            end
            S_OFF: begin
                if (ph_done) begin
                    phase_d = '0;
                    if (blk_q != '0) begin
                        state_d = S_ON;
                        led_n_d = 1'b0;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            default: begin
                if (ph_done) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    tick_d  = '0;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
        endcase

        // A new event on the granting edge overrides the clear so it is served again later.
        pend_d = pend_d | ev;

        if (!en) begin
            state_d = S_IDLE;
            tick_d  = '0;
            phase_d = '0;
            blk_d   = '0;
            gnt_d   = '0;
            pend_d  = '0;
            led_n_d = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            phase_q <= '0;
            blk_q   <= '0;
            gnt_q   <= '0;
            pend_q  <= '0;
            led_n_q <= 1'b1;
            busy_q  <= 1'b0;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            blk_q   <= blk_d;
            gnt_q   <= gnt_d;
            pend_q  <= pend_d;
            led_n_q <= led_n_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign led_n = led_n_q;
    assign busy  = busy_q;
    assign gnt   = gnt_q;
    assign pend  = pend_q;

endmodule

// File: tb/tb_hmi_led_sched.sv
// Bench for hmi_led_sched with TICK_DIV=4, ON_T=2, OFF_T=1, GAP_T=3 (ON 8, OFF 4, GAP 12 clks).
module tb_hmi_led_sched;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] ev;
    logic       led_n;
    logic       busy;
    logic [2:0] gnt;
    logic [2:0] pend;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk_sys = ~clk_sys;

    hmi_led_sched #(
        .TICK_DIV(4),
        .ON_T    (2),
        .OFF_T   (1),
        .GAP_T   (3)
    ) dut (
        .clk_sys(clk_sys),
        .rst_n  (rst_n),
        .en     (en),
        .ev     (ev),
        .led_n  (led_n),
        .busy   (busy),
        .gnt    (gnt),
        .pend   (pend)
    );

    // Expected output sample: {led_n, busy, gnt, pend}
    typedef logic [7:0] exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [2:0]  ev;
        int unsigned n;
        logic [1:0]  ord [3];
    } vec_t;

    vec_t vecs[6];

    function automatic exp_t mk(logic l, logic b, logic [2:0] g, logic [2:0] p);
        return {l, b, g, p};
    endfunction

    // Blink code of src: (src+1) x (8 lit, 4 dark) then 12 dark; pend switches at index sw.
    task automatic push_code(input logic [1:0] src, input logic [2:0] p0,
                             input logic [2:0] p1, input int unsigned sw);
        logic [2:0] g;
        logic       l;
        int unsigned len;
        g   = 3'b001 << src;
        len = 12 * (int'(src) + 1) + 12;
        for (int unsigned c = 0; c < len; c++) begin
            l = 1'b1;
            if (c / 12 <= int'(src) && c % 12 < 8) l = 1'b0;
            exp_q.push_back(mk(l, 1'b1, g, (c < sw) ? p0 : p1));
        end
    endtask

    task automatic push_idle(input logic [2:0] p, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) exp_q.push_back(mk(1'b1, 1'b0, 3'b000, p));
    endtask

    task automatic cycle(input logic [2:0] e, input logic en_v, input logic rst_v,
                         input string name);
        exp_t e_v;
        exp_t a_v;
        @(posedge clk_sys);
        #1;
        ev    = e;
        en    = en_v;
        rst_n = rst_v;
        @(negedge clk_sys);
        checks++;
        a_v = {led_n, busy, gnt, pend};
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got {led_n,busy,gnt,pend}=%b", name, a_v);
        end else begin
            e_v = exp_q.pop_front();
            if (a_v !== e_v) begin
                failures++;
                $display("FAIL %s @%0t: got {led_n,busy,gnt,pend}=%b expected %b",
                         name, $time, a_v, e_v);
            end
        end
    endtask

    initial begin
        logic [2:0] rem;
        int unsigned t;

        vecs[0] = '{ev: 3'b001, n: 1, ord: '{2'd0, 2'd0, 2'd0}};
        vecs[1] = '{ev: 3'b100, n: 1, ord: '{2'd2, 2'd0, 2'd0}};
        vecs[2] = '{ev: 3'b010, n: 1, ord: '{2'd1, 2'd0, 2'd0}};
        vecs[3] = '{ev: 3'b101, n: 2, ord: '{2'd0, 2'd2, 2'd0}};
        vecs[4] = '{ev: 3'b111, n: 3, ord: '{2'd0, 2'd1, 2'd2}};
        vecs[5] = '{ev: 3'b110, n: 2, ord: '{2'd1, 2'd2, 2'd0}};

        rst_n = 1'b0;
        en    = 1'b0;
        ev    = '0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        checks++;
        if ({led_n, busy, gnt, pend} !== 8'b1_0_000_000) begin
            failures++;
            $display("FAIL reset: got {led_n,busy,gnt,pend}=%b expected 10000000",
                     {led_n, busy, gnt, pend});
        end
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;

        // Table: single and simultaneous events, served in fixed-priority order.
        foreach (vecs[i]) begin
            push_idle(3'b000, 1);
            push_idle(vecs[i].ev, 1);
            rem = vecs[i].ev;
            for (int unsigned k = 0; k < vecs[i].n; k++) begin
                rem = rem & ~(3'b001 << vecs[i].ord[k]);
                push_code(vecs[i].ord[k], rem, rem, 0);
                push_idle(rem, 1);
            end
            t = 0;
            while (exp_q.size() > 0) begin
                cycle((t == 0) ? vecs[i].ev : 3'b000, 1'b1, 1'b1, "vector");
                t++;
            end
        end

        // ev[1] re-pulsed during its own code (3 times): exactly one extra code.
        push_idle(3'b000, 1);
        push_idle(3'b010, 1);
        push_code(2'd1, 3'b000, 3'b010, 2);
        push_idle(3'b010, 1);
        push_code(2'd1, 3'b000, 3'b000, 0);
        push_idle(3'b000, 3);
        t = 0;
        while (exp_q.size() > 0) begin
            cycle((t == 0 || t == 3 || t == 10 || t == 20) ? 3'b010 : 3'b000,
                  1'b1, 1'b1, "repulse");
            t++;
        end

        // en dropped mid-ON of ev[2] code flushes everything; ev ignored while en low.
        push_idle(3'b000, 1);
        push_idle(3'b100, 1);
        exp_q.push_back(mk(1'b0, 1'b1, 3'b100, 3'b000));
        exp_q.push_back(mk(1'b0, 1'b1, 3'b100, 3'b000));
        exp_q.push_back(mk(1'b0, 1'b1, 3'b100, 3'b001));
        exp_q.push_back(mk(1'b0, 1'b1, 3'b100, 3'b001));
        push_idle(3'b000, 10);
        t = 0;
        while (exp_q.size() > 0) begin
            cycle((t == 0) ? 3'b100 : (t == 3) ? 3'b001 : (t == 7) ? 3'b011 : 3'b000,
                  (t < 5 || t >= 10), 1'b1, "en_drop");
            t++;
        end

        // rst_n pulsed low for one clk during OFF: immediate reset values, nothing resumes.
        push_idle(3'b000, 1);
        push_idle(3'b001, 1);
        for (int unsigned c = 0; c < 9; c++)
            exp_q.push_back(mk((c < 8) ? 1'b0 : 1'b1, 1'b1, 3'b001,
                               (c < 4) ? 3'b000 : 3'b010));
        push_idle(3'b000, 12);
        t = 0;
        while (exp_q.size() > 0) begin
            cycle((t == 0) ? 3'b001 : (t == 5) ? 3'b010 : 3'b000,
                  1'b1, (t == 11) ? 1'b0 : 1'b1, "reset_mid");
            t++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
